sram_rmw_master: RTL

//  Initiator-side controller for the 512x32 single-port SRAM wrapper.

---
 rtl/sram_pkg.sv | 30 +++
 rtl/sram_rmw_master_if.sv | 55 +++++
 rtl/sram_byte_merge.sv | 28 ++
 rtl/sram_rmw_master.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
//   Shared definitions for the SRAM read-modify-write master and the
//   512x32 single-port SRAM wrapper it drives.
//   Contents:
//     SRAM_ADDR_W  word address width of the SRAM (512 words)
//     SRAM_DATA_W  data width of the SRAM
//     STRB_W       byte-strobe width (one bit per data byte)
//     state_t      controller state encoding
// -----------------------------------------------------------------------------
package sram_pkg;

   localparam int SRAM_ADDR_W = 9;
   localparam int SRAM_DATA_W = 32;
   localparam int STRB_W      = SRAM_DATA_W / 8;

   // IDLE: waiting for a request
   // RD  : read pulse on the SRAM
   // CAP : capture read data (and merge for partial writes)
   // WR  : write pulse on the SRAM
   // RSP : response held until the consumer takes it
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      CAP  = 3'd2,
      WR   = 3'd3,
      RSP  = 3'd4
   } state_t;

endpackage

// File: rtl/sram_rmw_master_if.sv
// -----------------------------------------------------------------------------
// sram_rmw_master_if
//   Bundles the CPU request/response handshake and the SRAM wrapper bus of
//   the read-modify-write master.
//   Signals:
//     req_valid/req_ready/req_addr/req_we/req_wstrb/req_wdata  request channel
//     rsp_valid/rsp_ready/rsp_rdata                            response channel
//     mem_en/mem_wen/mem_addr/mem_wdata/mem_rdata              SRAM wrapper bus
//   Modports:
//     slave  : the controller (consumes requests, drives the SRAM bus)
//     master : the surrounding system (issues requests, models the SRAM)
// -----------------------------------------------------------------------------
interface sram_rmw_master_if
   import sram_pkg::*;
#(
   parameter int ADDR_W = SRAM_ADDR_W,
   parameter int DATA_W = SRAM_DATA_W
);

   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_W-1:0]     req_addr;
   logic                  req_we;
   logic [DATA_W/8-1:0]   req_wstrb;
   logic [DATA_W-1:0]     req_wdata;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_W-1:0]     rsp_rdata;

   logic                  mem_en;
   logic                  mem_wen;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W-1:0]     mem_rdata;

   modport slave (
      input  req_valid, req_addr, req_we, req_wstrb, req_wdata,
      output req_ready,
      output rsp_valid, rsp_rdata,
      input  rsp_ready,
      output mem_en, mem_wen, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output req_valid, req_addr, req_we, req_wstrb, req_wdata,
      input  req_ready,
      input  rsp_valid, rsp_rdata,
      output rsp_ready,
      input  mem_en, mem_wen, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/sram_byte_merge.sv
// -----------------------------------------------------------------------------
// sram_byte_merge
//   Combinational byte merge for read-modify-write: each output byte takes
//   the new data byte when its strobe is set, otherwise the old byte.
//   Ports:
//     old_data  in   DATA_W     word read from the SRAM
//     new_data  in   DATA_W     write data from the request
//     strb      in   DATA_W/8   byte enables
//     merged    out  DATA_W     merged word
// -----------------------------------------------------------------------------
module sram_byte_merge #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]   old_data,
   input  logic [DATA_W-1:0]   new_data,
   input  logic [DATA_W/8-1:0] strb,
   output logic [DATA_W-1:0]   merged
);

   genvar gi;
   generate
      for (gi = 0; gi < DATA_W / 8; gi++) begin : g_byte
         assign merged[gi*8 +: 8] = strb[gi] ? new_data[gi*8 +: 8]
                                             : old_data[gi*8 +: 8];
      end
   endgenerate

endmodule

// File: rtl/sram_rmw_master.sv
// -----------------------------------------------------------------------------
// sram_rmw_master
//   Initiator-side controller for the 512x32 single-port SRAM wrapper.
//   Accepts word requests with byte strobes, issues single-cycle enable
//   pulses to the wrapper, and turns partial writes into read-modify-write
//   (the wrapper only writes full words).
//   Ports:
//     clk    in   clock
//     reset  in   synchronous, active-high reset
//     bus    slave modport of sram_rmw_master_if (request, response and
//            SRAM wrapper signals)
//   Latency from accept to first rsp_valid cycle:
//     read 3, full write 2, partial write 4, zero-strobe write 1.
// -----------------------------------------------------------------------------
module sram_rmw_master
   import sram_pkg::*;
#(
   parameter int ADDR_W = SRAM_ADDR_W,
   parameter int DATA_W = SRAM_DATA_W
) (
   input  logic                clk,
   input  logic                reset,
   sram_rmw_master_if.slave    bus
);

   localparam int SW = DATA_W / 8;

   state_t              state_q,     state_d;
   logic                we_q,        we_d;
   logic [SW-1:0]       wstrb_q,     wstrb_d;
   logic [DATA_W-1:0]   wdata_q,     wdata_d;
   logic                mem_en_q,    mem_en_d;
   logic                mem_wen_q,   mem_wen_d;
   logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic [DATA_W-1:0]   merged;

   sram_byte_merge #(
      .DATA_W (DATA_W)
   ) u_merge (
      .old_data (bus.mem_rdata),
      .new_data (wdata_q),
      .strb     (wstrb_q),
      .merged   (merged)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         wstrb_q     <= '0;
         wdata_q     <= '0;
         mem_en_q    <= 1'b0;
         mem_wen_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         wstrb_q     <= wstrb_d;
         wdata_q     <= wdata_d;
         mem_en_q    <= mem_en_d;
         mem_wen_q   <= mem_wen_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // The SRAM strobes are registered, so they are computed here for the
   // state being entered: mem_en is high exactly during RD and WR, and
   // RD/WR are never adjacent, so pulses are always separated by a low cycle.
   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      wstrb_d     = wstrb_q;
      wdata_d     = wdata_q;
      mem_en_d    = 1'b0;
      mem_wen_d   = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rsp_rdata_d = rsp_rdata_q;

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               we_d       = bus.req_we;
               wstrb_d    = bus.req_wstrb;
               wdata_d    = bus.req_wdata;
               mem_addr_d = bus.req_addr;
               if (!bus.req_we || (bus.req_wstrb != '0 && bus.req_wstrb != '1)) begin
                  // Reads and partial writes both start with a read pulse.
                  state_d  = RD;
                  mem_en_d = 1'b1;
               end else if (bus.req_wstrb == '1) begin
                  state_d     = WR;
                  mem_en_d    = 1'b1;
                  mem_wen_d   = 1'b1;
                  mem_wdata_d = bus.req_wdata;
                  rsp_rdata_d = bus.req_wdata;
               end else begin
                  // No bytes enabled: nothing to write, answer at once.
                  state_d     = RSP;
                  rsp_rdata_d = '0;
               end
            end
         end

         RD: begin
            state_d = CAP;
         end

         CAP: begin
            // mem_rdata is valid in this cycle (one cycle after the pulse).
            if (we_q) begin
               state_d     = WR;
               mem_en_d    = 1'b1;
               mem_wen_d   = 1'b1;
               mem_wdata_d = merged;
               rsp_rdata_d = merged;
            end else begin
               state_d     = RSP;
               rsp_rdata_d = bus.mem_rdata;
            end
         end

         WR: begin
            state_d = RSP;
         end

         RSP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = (state_q == RSP);
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_wen   = mem_wen_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

endmodule
